// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared widths and FSM encoding for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_ADDR_W = 5;
    localparam int c_DATA_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_RD_ADDR = 3'd1;
    localparam state_t c_ST_RD_DATA = 3'd2;
    localparam state_t c_ST_WR      = 3'd3;
    localparam state_t c_ST_DONE    = 3'd4;

    function automatic logic is_read_state(input state_t s);
        return (s == c_ST_RD_ADDR) || (s == c_ST_RD_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester-side bundle of both arbiter ports plus shared status.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) ();

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p0_ack, p1_ack, rdata, busy
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p0_ack, p1_ack, rdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant; a tie goes to the port not granted last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       valid
);

    assign gnt[0] = enable & req[0] & (~req[1] |  last_grant);
    assign gnt[1] = enable & req[1] & (~req[0] | ~last_grant);
    assign valid  = |gnt;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single-ported memory between fetch and load/store ports.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      bus,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_arb_valid;
    logic              w_arb_en;

    logic              w_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              r_last_grant;
    logic              r_gnt_id;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              r_rd_en;
    logic              r_wr_en;
    logic              r_p0_ack;
    logic              r_p1_ack;
    logic              r_busy;

    logic              w_rd_en_nxt;
    logic              w_wr_en_nxt;
    logic              w_p0_ack_nxt;
    logic              w_p1_ack_nxt;
    logic              w_busy_nxt;

    assign w_arb_en = (r_state == c_ST_IDLE);
    assign w_req    = {bus.p1_req, bus.p0_req};

    rr_arbiter2 u_rr_arbiter2 (
        .req        (w_req),
        .last_grant (r_last_grant),
        .enable     (w_arb_en),
        .gnt        (w_gnt),
        .valid      (w_arb_valid)
    );

    assign w_sel       = w_gnt[1];
    assign w_sel_we    = w_sel ? bus.p1_we    : bus.p0_we;
    assign w_sel_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = w_sel_we ? c_ST_WR : c_ST_RD_ADDR;
                end
            end
            c_ST_RD_ADDR: w_state_nxt = c_ST_RD_DATA;
            c_ST_RD_DATA: w_state_nxt = c_ST_DONE;
            c_ST_WR:      w_state_nxt = c_ST_DONE;
            c_ST_DONE:    w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered so the memory sees clean edges.
    always_comb begin
        w_rd_en_nxt  = is_read_state(w_state_nxt);
        w_wr_en_nxt  = (w_state_nxt == c_ST_WR);
        w_p0_ack_nxt = (w_state_nxt == c_ST_DONE) && !r_gnt_id;
        w_p1_ack_nxt = (w_state_nxt == c_ST_DONE) &&  r_gnt_id;
        w_busy_nxt   = (w_state_nxt != c_ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en  <= 1'b0;
            r_wr_en  <= 1'b0;
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rd_en  <= w_rd_en_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_p0_ack <= w_p0_ack_nxt;
            r_p1_ack <= w_p1_ack_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Request fields are captured once at acceptance; later changes on the port are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_gnt_id     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_arb_valid) begin
            r_last_grant <= w_sel;
            r_gnt_id     <= w_sel;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == c_ST_RD_DATA) begin
            r_rdata <= mem_data;
        end
    end

    assign mem_read_en  = r_rd_en;
    assign mem_write_en = r_wr_en;
    assign mem_address  = r_addr;
    assign mem_data     = r_wr_en ? r_wdata : 'z;

    assign bus.p0_ack   = r_p0_ack;
    assign bus.p1_ack   = r_p1_ack;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = c_ADDR_W;
    localparam int DW = c_DATA_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [AW-1:0] mem_address;
    wire  [DW-1:0] mem_data;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_address  (mem_address),
        .mem_data     (mem_data)
    );

    function automatic logic [7:0] preload(input int i);
        return 8'(i * 17);
    endfunction

    // Memory: captures on a read_en edge, drives the bus in the following read cycle.
    logic [DW-1:0] mem_arr [32];
    logic [DW-1:0] mem_q;
    logic          mem_rd_v;
    logic          mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem_arr[i] <= preload(i);
            mem_loaded <= 1'b1;
        end else if (mem_write_en) begin
            mem_arr[mem_address] <= mem_data;
        end
        mem_q    <= mem_arr[mem_address];
        mem_rd_v <= mem_read_en;
    end

    assign mem_data = (mem_read_en && mem_rd_v) ? mem_q : 'z;

    // Transaction-level reference
    logic [7:0] mem_ref [32];
    int         cyc;
    int         m_free_at, m_acc, m_ack;
    bit         m_last, m_port, m_we;
    logic [4:0] m_addr;
    logic [7:0] m_wdata, m_rd_exp, m_rdata;
    bit         accepted [2];
    int         acked;
    int         grant_q [$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_free_at   = 0;
        m_acc       = -100;
        m_ack       = -100;
        m_last      = 1'b1;
        m_addr      = '0;
        m_rdata     = '0;
        accepted[0] = 1'b0;
        accepted[1] = 1'b0;
    endtask

    task automatic set_port(input int p, input bit req, input bit we,
                            input logic [4:0] a, input logic [7:0] d);
        if (p == 0) begin
            bus_if.p0_req = req; bus_if.p0_we = we; bus_if.p0_addr = a; bus_if.p0_wdata = d;
        end else begin
            bus_if.p1_req = req; bus_if.p1_we = we; bus_if.p1_addr = a; bus_if.p1_wdata = d;
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_read_en",  int'(mem_read_en),  0);
        chk("rst_write_en", int'(mem_write_en), 0);
        chk("rst_address",  int'(mem_address),  0);
        chk("rst_rdata",    int'(bus_if.rdata), 0);
        chk("rst_p0_ack",   int'(bus_if.p0_ack), 0);
        chk("rst_p1_ack",   int'(bus_if.p1_ack), 0);
        chk("rst_busy",     int'(bus_if.busy),  0);
    endtask

    // One clock: apply the arbitration rules at the edge, then compare every output.
    task automatic step();
        bit         r0, r1, w0, w1, win;
        logic [4:0] a0, a1;
        logic [7:0] d0, d1;
        r0 = bus_if.p0_req; w0 = bus_if.p0_we; a0 = bus_if.p0_addr; d0 = bus_if.p0_wdata;
        r1 = bus_if.p1_req; w1 = bus_if.p1_we; a1 = bus_if.p1_addr; d1 = bus_if.p1_wdata;
        @(posedge clk);
        cyc++;
        acked = -1;
        if (cyc >= m_free_at && (r0 || r1)) begin
            win       = (r0 && r1) ? !m_last : r1;
            m_last    = win;
            m_port    = win;
            m_we      = win ? w1 : w0;
            m_addr    = win ? a1 : a0;
            m_wdata   = win ? d1 : d0;
            m_acc     = cyc;
            m_ack     = cyc + (m_we ? 1 : 2);
            m_free_at = cyc + (m_we ? 3 : 4);
            if (m_we) mem_ref[m_addr] = m_wdata;
            else      m_rd_exp = mem_ref[m_addr];
            grant_q.push_back(int'(win));
            accepted[win] = 1'b1;
        end
        if (cyc == m_ack) begin
            acked = int'(m_port);
            accepted[m_port] = 1'b0;
            if (!m_we) m_rdata = m_rd_exp;
        end
        #1;
        chk("p0_ack",   int'(bus_if.p0_ack), int'(cyc == m_ack && m_port == 1'b0));
        chk("p1_ack",   int'(bus_if.p1_ack), int'(cyc == m_ack && m_port == 1'b1));
        chk("busy",     int'(bus_if.busy),   int'(cyc >= m_acc && cyc < m_free_at - 1));
        chk("read_en",  int'(mem_read_en),   int'(!m_we && cyc >= m_acc && cyc < m_ack));
        chk("write_en", int'(mem_write_en),  int'(m_we && cyc == m_acc));
        chk("address",  int'(mem_address),   int'(m_addr));
        chk("rdata",    int'(bus_if.rdata),  int'(m_rdata));
        chk("en_excl",  int'(mem_read_en && mem_write_en), 0);
        if (mem_write_en)                        chk("wr_bus", int'(mem_data), int'(m_wdata));
        if (mem_read_en && cyc == m_acc + 1)     chk("rd_bus", int'(mem_data), int'(m_rd_exp));
    endtask

    task automatic wait_ack(input int p, input int max_cyc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (acked != p && n < max_cyc);
        chk($sformatf("ack_seen_p%0d", p), acked, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int         port;
        bit         we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    vec_t vecs [9];
    int   ack_p [$];
    int   ack_d [$];
    bit   pend [2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{0, 1'b1, 5'h03, 8'hA5, 8'h00, 2};
        vecs[1] = '{0, 1'b0, 5'h03, 8'h00, 8'hA5, 3};
        vecs[2] = '{1, 1'b1, 5'h1F, 8'h3C, 8'h00, 2};
        vecs[3] = '{1, 1'b0, 5'h1F, 8'h00, 8'h3C, 3};
        vecs[4] = '{1, 1'b1, 5'h00, 8'h5A, 8'h00, 2};
        vecs[5] = '{0, 1'b0, 5'h00, 8'h00, 8'h5A, 3};
        vecs[6] = '{0, 1'b1, 5'h10, 8'hFF, 8'h00, 2};
        vecs[7] = '{1, 1'b0, 5'h10, 8'h00, 8'hFF, 3};
        vecs[8] = '{0, 1'b0, 5'h01, 8'h00, 8'h11, 3};

        for (int i = 0; i < 32; i++) mem_ref[i] = preload(i);
        cyc   = 0;
        acked = -1;
        rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, 5'h00, 8'h00);
        set_port(1, 1'b0, 1'b0, 5'h00, 8'h00);
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();

        // Table-driven single transactions
        for (int i = 0; i < 9; i++) begin
            set_port(vecs[i].port, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            wait_ack(vecs[i].port, 10, n);
            chk($sformatf("vec%0d_latency", i), n, vecs[i].exp_lat);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), int'(bus_if.rdata), int'(vecs[i].exp_rdata));
            set_port(vecs[i].port, 1'b0, 1'b0, 5'h00, 8'h00);
            step();
        end

        // Both ports read from reset, then keep requesting: strict alternation
        do_reset();
        set_port(0, 1'b1, 1'b0, 5'h01, 8'h00);
        set_port(1, 1'b1, 1'b0, 5'h02, 8'h00);
        grant_q.delete();
        ack_p.delete();
        ack_d.delete();
        for (int i = 0; i < 60 && grant_q.size() < 6; i++) begin
            step();
            if (acked >= 0) begin ack_p.push_back(acked); ack_d.push_back(int'(bus_if.rdata)); end
        end
        set_port(0, 1'b0, 1'b0, 5'h00, 8'h00);
        set_port(1, 1'b0, 1'b0, 5'h00, 8'h00);
        for (int i = 0; i < 6; i++) step();
        chk("tie_grant_count", grant_q.size(), 6);
        for (int i = 0; i < grant_q.size() && i < 6; i++)
            chk($sformatf("tie_grant%0d", i), grant_q[i], i % 2);
        if (ack_p.size() >= 2) begin
            chk("tie_first_port",  ack_p[0], 0);
            chk("tie_first_data",  ack_d[0], 8'h11);
            chk("tie_second_port", ack_p[1], 1);
            chk("tie_second_data", ack_d[1], 8'h22);
        end else begin
            chk("tie_ack_count", ack_p.size(), 2);
        end

        // p1 writes the top address while p0 alters its in-flight request
        set_port(0, 1'b1, 1'b0, 5'h05, 8'h00);
        set_port(1, 1'b1, 1'b1, 5'h1F, 8'h3C);
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        for (int i = 0; i < 20 && (pend[0] || pend[1]); i++) begin
            step();
            if (acked == 0) begin pend[0] = 1'b0; set_port(0, 1'b0, 1'b0, 5'h06, 8'h00); end
            if (acked == 1) begin pend[1] = 1'b0; set_port(1, 1'b0, 1'b0, 5'h00, 8'h00); end
            if (accepted[0]) begin bus_if.p0_addr = 5'h06; bus_if.p0_we = 1'b1; bus_if.p0_wdata = 8'hEE; end
        end
        chk("wrap_both_done", int'(pend[0] || pend[1]), 0);
        step();
        set_port(1, 1'b1, 1'b0, 5'h1F, 8'h00);
        wait_ack(1, 10, n);
        chk("wrap_readback", int'(bus_if.rdata), 8'h3C);
        set_port(1, 1'b0, 1'b0, 5'h00, 8'h00);
        step();

        // Asynchronous reset in the middle of RD_DATA
        set_port(0, 1'b1, 1'b0, 5'h02, 8'h00);
        step();
        step();
        chk("mid_read_en", int'(mem_read_en), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        #1 rst_n = 1'b1;
        model_reset();
        wait_ack(0, 10, n);
        chk("post_reset_rdata", int'(bus_if.rdata), 8'h22);
        set_port(0, 1'b0, 1'b0, 5'h00, 8'h00);
        step();

        // Request left high through the IDLE cycle after DONE is a second read
        set_port(0, 1'b1, 1'b0, 5'h03, 8'h00);
        wait_ack(0, 10, n);
        chk("hold_rd1", int'(bus_if.rdata), 8'hA5);
        step();
        step();
        chk("hold_regrant", int'(accepted[0]), 1);
        set_port(0, 1'b0, 1'b0, 5'h00, 8'h00);
        wait_ack(0, 10, n);
        chk("hold_rd2", int'(bus_if.rdata), 8'hA5);
        step();

        // Randomised traffic against the model
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (acked == p) pend[p] = 1'b0;
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_port(p, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                                 8'($urandom_range(0, 255)));
                        pend[p] = 1'b1;
                    end else begin
                        set_port(p, 1'b0, 1'b0, 5'h00, 8'h00);
                    end
                end else if (accepted[p] && $urandom_range(0, 1) == 1) begin
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                             8'($urandom_range(0, 255)));
                end
            end
        end
        set_port(0, 1'b0, 1'b0, 5'h00, 8'h00);
        set_port(1, 1'b0, 1'b0, 5'h00, 8'h00);
        for (int i = 0; i < 6; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
